// File: rtl/l1cache_2way.sv
// l1cache_2way: 2-way set-associative L1 cache with multi-word blocks.
// Write-back / write-allocate with one LRU bit per set. The processor port is
// word-addressed and stall-based. The memory port moves one whole block per request.
module l1cache_2way #(
  parameter int SET_BITS    = 2,
  parameter int OFFSET_BITS = 2
) (
  input  logic                            clk,
  input  logic                            proc_reset_n,
  input  logic                            proc_read,
  input  logic                            proc_write,
  input  logic [29:0]                     proc_addr,
  input  logic [31:0]                     proc_wdata,
  output logic                            proc_stall,
  output logic [31:0]                     proc_rdata,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [29-OFFSET_BITS:0]         mem_addr,
  output logic [(32<<OFFSET_BITS)-1:0]    mem_wdata,
  input  logic [(32<<OFFSET_BITS)-1:0]    mem_rdata,
  input  logic                            mem_ready
);
  localparam int TAG_W = 30 - SET_BITS - OFFSET_BITS;
  localparam int NSETS = 1 << SET_BITS;
  localparam int BLK_W = 32 << OFFSET_BITS;
  localparam int BA_W  = 30 - OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, WB, ALLOC} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             valid_q [NSETS];
  logic [1:0]             dirty_q [NSETS];
  logic [NSETS-1:0]       lru_q;
  logic [TAG_W-1:0]       tag_q   [NSETS][2];
  logic [BLK_W-1:0]       data_q  [NSETS][2];

  logic                   victim_q, victim_d;
  logic [BA_W-1:0]        req_blk_q, req_blk_d;
  logic                   mem_read_d, mem_write_d;
  logic [BA_W-1:0]        mem_addr_d;
  logic [BLK_W-1:0]       mem_wdata_d;

  logic [SET_BITS-1:0]    set_idx;
  logic [OFFSET_BITS-1:0] word_idx;
  logic [TAG_W-1:0]       tag_in;
  logic [OFFSET_BITS+4:0] woff;
  logic                   hit0, hit1, hit, hit_way;
  logic                   vict, vict_dirty;
  logic                   fill_en, hit_upd, wr_hit;
  logic [SET_BITS-1:0]    fset;
  logic [TAG_W-1:0]       ftag;

  assign set_idx  = proc_addr[OFFSET_BITS +: SET_BITS];
  assign word_idx = proc_addr[OFFSET_BITS-1:0];
  assign tag_in   = proc_addr[29 -: TAG_W];
  assign woff     = {word_idx, 5'd0};
  // The refill target comes from the latched request so a moving address cannot redirect it
  assign fset     = req_blk_q[SET_BITS-1:0];
  assign ftag     = req_blk_q[BA_W-1 -: TAG_W];

  // Tag compare, read mux, stall and victim choice for the presented address
  always_comb begin
    hit0       = valid_q[set_idx][0] && (tag_q[set_idx][0] == tag_in);
    hit1       = valid_q[set_idx][1] && (tag_q[set_idx][1] == tag_in);
    hit        = hit0 | hit1;
    hit_way    = hit1 & ~hit0;
    proc_stall = (proc_read | proc_write) & ~hit;
    proc_rdata = 32'd0;
    if (proc_read && hit) proc_rdata = data_q[set_idx][hit_way][woff +: 32];
    if (!valid_q[set_idx][0])      vict = 1'b0;
    else if (!valid_q[set_idx][1]) vict = 1'b1;
    else                           vict = lru_q[set_idx];
    vict_dirty = valid_q[set_idx][vict] & dirty_q[set_idx][vict];
  end

  // Next-state and registered memory-port values
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read;
    mem_write_d = mem_write;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    victim_d    = victim_q;
    req_blk_d   = req_blk_q;
    fill_en     = 1'b0;
    hit_upd     = 1'b0;
    wr_hit      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (proc_read || proc_write) begin
          if (hit) begin
            hit_upd = 1'b1;
            wr_hit  = proc_write & ~proc_read;
          end else begin
            victim_d  = vict;
            req_blk_d = proc_addr[29:OFFSET_BITS];
            if (vict_dirty) begin
              state_d     = WB;
              mem_write_d = 1'b1;
              mem_addr_d  = {tag_q[set_idx][vict], set_idx};
              mem_wdata_d = data_q[set_idx][vict];
            end else begin
              state_d    = ALLOC;
              mem_read_d = 1'b1;
              mem_addr_d = proc_addr[29:OFFSET_BITS];
            end
          end
        end
      end
      WB: begin
        if (mem_ready) begin
          state_d     = ALLOC;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = req_blk_q;
        end
      end
      ALLOC: begin
        if (mem_ready) begin
          state_d    = IDLE;
          mem_read_d = 1'b0;
          fill_en    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, memory-port registers and transaction latches
  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      state_q   <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      victim_q  <= 1'b0;
      req_blk_q <= '0;
    end else begin
      state_q   <= state_d;
      mem_read  <= mem_read_d;
      mem_write <= mem_write_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      victim_q  <= victim_d;
      req_blk_q <= req_blk_d;
    end
  end

  // Valid, dirty and LRU bookkeeping
  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      for (int s = 0; s < NSETS; s++) begin
        valid_q[s] <= 2'b00;
        dirty_q[s] <= 2'b00;
      end
      lru_q <= '0;
    end else begin
      if (hit_upd) begin
        lru_q[set_idx] <= ~hit_way;
        if (wr_hit) dirty_q[set_idx][hit_way] <= 1'b1;
      end
      if (fill_en) begin
        valid_q[fset][victim_q] <= 1'b1;
        dirty_q[fset][victim_q] <= 1'b0;
      end
    end
  end

  // Tag and data arrays; unreset, and a reset edge blocks any write
  always_ff @(posedge clk) begin
    if (proc_reset_n && fill_en) begin
      data_q[fset][victim_q] <= mem_rdata;
      tag_q[fset][victim_q]  <= ftag;
    end else if (proc_reset_n && wr_hit) begin
      data_q[set_idx][hit_way][woff +: 32] <= proc_wdata;
    end
  end
endmodule

// File: tb/tb_l1cache_2way.sv
// Directed testbench for l1cache_2way with default parameters.
module tb_l1cache_2way;
  logic         clk = 1'b0;
  logic         proc_reset_n;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] B0  = {32'h33, 32'h22, 32'h11, 32'h00};
  localparam logic [127:0] B1  = {32'h203, 32'h202, 32'h201, 32'h200};
  localparam logic [127:0] B3  = {32'h303, 32'h302, 32'h301, 32'h300};
  localparam logic [127:0] BA  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] BC  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
  localparam logic [127:0] B0D = {32'h33, 32'h22, 32'h11, 32'hDEADBEEF};
  localparam logic [127:0] BAW = {32'hA3, 32'hA2, 32'h12345678, 32'hA0};

  l1cache_2way dut (
    .clk(clk), .proc_reset_n(proc_reset_n), .proc_read(proc_read),
    .proc_write(proc_write), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_stall(proc_stall), .proc_rdata(proc_rdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic req(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d);
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = d;
  endtask

  task automatic do_reset;
    proc_reset_n = 1'b0;
    req(1'b0, 1'b0, 30'h0, 32'h0);
    mem_ready = 1'b0;
    mem_rdata = '0;
    tick;
    tick;
    proc_reset_n = 1'b1;
  endtask

  // Clean miss already presented: refill, then one hit cycle for LRU/write
  task automatic fill(input logic [127:0] blk);
    tick;
    mem_rdata = blk;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL rst_mem_read got=%b exp=0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL rst_mem_write got=%b exp=0", mem_write); end
    checks++; if (mem_addr !== 28'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 128'h0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (proc_stall !== 1'b0) begin failures++; $display("FAIL rst_idle_stall got=%b exp=0", proc_stall); end
    checks++; if (proc_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", proc_rdata); end
    req(1'b1, 1'b0, 30'h0, 32'h0);
    #1;
    checks++; if (proc_stall !== 1'b1) begin failures++; $display("FAIL rst_cold_stall got=%b exp=1", proc_stall); end
  endtask

  task automatic test_cold_read;
    do_reset;
    req(1'b1, 1'b0, 30'h10, 32'h0);
    #1;
    checks++; if (proc_stall !== 1'b1) begin failures++; $display("FAIL cold_stall got=%b exp=1", proc_stall); end
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL cold_early_read got=%b exp=0", mem_read); end
    tick;
    checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL cold_mem_read got=%b exp=1", mem_read); end
    checks++; if (mem_addr !== 28'h04) begin failures++; $display("FAIL cold_mem_addr got=%h exp=04", mem_addr); end
    checks++; if (proc_stall !== 1'b1) begin failures++; $display("FAIL cold_stall2 got=%b exp=1", proc_stall); end
    mem_rdata = B0;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    #1;
    checks++; if (proc_stall !== 1'b0) begin failures++; $display("FAIL cold_unstall got=%b exp=0", proc_stall); end
    checks++; if (proc_rdata !== 32'h0) begin failures++; $display("FAIL cold_rdata0 got=%h exp=0", proc_rdata); end
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL cold_read_drop got=%b exp=0", mem_read); end
    req(1'b1, 1'b0, 30'h11, 32'h0);
    #1;
    checks++; if (proc_rdata !== 32'h11) begin failures++; $display("FAIL cold_rdata1 got=%h exp=11", proc_rdata); end
    req(1'b1, 1'b1, 30'h11, 32'hFFFFFFFF);
    #1;
    checks++; if (proc_rdata !== 32'h11) begin failures++; $display("FAIL rdwr_rdata got=%h exp=11", proc_rdata); end
    tick;
    req(1'b1, 1'b0, 30'h11, 32'h0);
    #1;
    checks++; if (proc_rdata !== 32'h11) begin failures++; $display("FAIL rdwr_ignored got=%h exp=11", proc_rdata); end
    req(1'b0, 1'b0, 30'h11, 32'h0);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    #1;
    checks++; if ({mem_read, mem_write} !== 2'b00) begin failures++; $display("FAIL idle_ready got=%b exp=00", {mem_read, mem_write}); end
    checks++; if (proc_rdata !== 32'h0) begin failures++; $display("FAIL noreq_rdata got=%h exp=0", proc_rdata); end
    req(1'b1, 1'b0, 30'h13, 32'h0);
    #1;
    checks++; if (proc_rdata !== 32'h33) begin failures++; $display("FAIL cold_rdata3 got=%h exp=33", proc_rdata); end
  endtask

  task automatic test_lru;
    do_reset;
    req(1'b1, 1'b0, 30'h10, 32'h0);
    fill(B0);
    req(1'b1, 1'b0, 30'h20, 32'h0);
    fill(B1);
    req(1'b1, 1'b0, 30'h10, 32'h0);
    #1;
    checks++; if (proc_stall !== 1'b0) begin failures++; $display("FAIL lru_hit10 got=%b exp=0", proc_stall); end
    tick;
    req(1'b1, 1'b0, 30'h30, 32'h0);
    tick;
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL lru_no_wb got=%b exp=0", mem_write); end
    checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL lru_mem_read got=%b exp=1", mem_read); end
    checks++; if (mem_addr !== 28'h0C) begin failures++; $display("FAIL lru_mem_addr got=%h exp=0c", mem_addr); end
    mem_rdata = B3;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    #1;
    checks++; if (proc_rdata !== 32'h300) begin failures++; $display("FAIL lru_rdata30 got=%h exp=300", proc_rdata); end
    req(1'b1, 1'b0, 30'h10, 32'h0);
    #1;
    checks++; if (proc_stall !== 1'b0) begin failures++; $display("FAIL lru_keep10 got=%b exp=0", proc_stall); end
    checks++; if (proc_rdata !== 32'h00) begin failures++; $display("FAIL lru_rdata10 got=%h exp=0", proc_rdata); end
    req(1'b1, 1'b0, 30'h20, 32'h0);
    #1;
    checks++; if (proc_stall !== 1'b1) begin failures++; $display("FAIL lru_evict20 got=%b exp=1", proc_stall); end
  endtask

  task automatic test_dirty_slow;
    do_reset;
    req(1'b1, 1'b0, 30'h10, 32'h0);
    fill(B0);
    req(1'b0, 1'b1, 30'h10, 32'hDEADBEEF);
    tick;
    req(1'b1, 1'b0, 30'h20, 32'h0);
    fill(B1);
    req(1'b1, 1'b0, 30'h30, 32'h0);
    tick;
    checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL wb_mem_write got=%b exp=1", mem_write); end
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL wb_mem_read got=%b exp=0", mem_read); end
    checks++; if (mem_addr !== 28'h04) begin failures++; $display("FAIL wb_mem_addr got=%h exp=04", mem_addr); end
    checks++; if (mem_wdata !== B0D) begin failures++; $display("FAIL wb_mem_wdata got=%h exp=%h", mem_wdata, B0D); end
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if ({mem_write, mem_read, proc_stall} !== 3'b101 || mem_addr !== 28'h04 || mem_wdata !== B0D) begin
        failures++;
        $display("FAIL wb_hold%0d got=%b/%h/%h exp=101/04/%h", i, {mem_write, mem_read, proc_stall}, mem_addr, mem_wdata, B0D);
      end
    end
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    checks++; if ({mem_write, mem_read} !== 2'b01) begin failures++; $display("FAIL wb_to_alloc got=%b exp=01", {mem_write, mem_read}); end
    checks++; if (mem_addr !== 28'h0C) begin failures++; $display("FAIL alloc_addr got=%h exp=0c", mem_addr); end
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if ({mem_write, mem_read, proc_stall} !== 3'b011 || mem_addr !== 28'h0C) begin
        failures++;
        $display("FAIL alloc_hold%0d got=%b/%h exp=011/0c", i, {mem_write, mem_read, proc_stall}, mem_addr);
      end
    end
    mem_rdata = B3;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    #1;
    checks++; if (proc_stall !== 1'b0) begin failures++; $display("FAIL dirty_unstall got=%b exp=0", proc_stall); end
    checks++; if (proc_rdata !== 32'h300) begin failures++; $display("FAIL dirty_rdata got=%h exp=300", proc_rdata); end
    req(1'b1, 1'b0, 30'h21, 32'h0);
    #1;
    checks++; if (proc_rdata !== 32'h201) begin failures++; $display("FAIL dirty_keep20 got=%h exp=201", proc_rdata); end
    req(1'b1, 1'b0, 30'h10, 32'h0);
    #1;
    checks++; if (proc_stall !== 1'b1) begin failures++; $display("FAIL dirty_gone10 got=%b exp=1", proc_stall); end
  endtask

  task automatic test_write_alloc;
    do_reset;
    req(1'b0, 1'b1, 30'h45, 32'h12345678);
    #1;
    checks++; if (proc_stall !== 1'b1) begin failures++; $display("FAIL wa_stall got=%b exp=1", proc_stall); end
    tick;
    checks++; if ({mem_read, mem_write} !== 2'b10) begin failures++; $display("FAIL wa_mem_req got=%b exp=10", {mem_read, mem_write}); end
    checks++; if (mem_addr !== 28'h11) begin failures++; $display("FAIL wa_mem_addr got=%h exp=11", mem_addr); end
    mem_rdata = BA;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    #1;
    checks++; if (proc_stall !== 1'b0) begin failures++; $display("FAIL wa_unstall got=%b exp=0", proc_stall); end
    tick;
    req(1'b1, 1'b0, 30'h45, 32'h0);
    #1;
    checks++; if (proc_rdata !== 32'h12345678) begin failures++; $display("FAIL wa_rdata got=%h exp=12345678", proc_rdata); end
    req(1'b1, 1'b0, 30'h47, 32'h0);
    #1;
    checks++; if (proc_rdata !== 32'hA3) begin failures++; $display("FAIL wa_other_word got=%h exp=a3", proc_rdata); end
    req(1'b1, 1'b0, 30'h85, 32'h0);
    fill(BC);
    req(1'b1, 1'b0, 30'hC5, 32'h0);
    tick;
    checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL wa_dirty_wb got=%b exp=1", mem_write); end
    checks++; if (mem_addr !== 28'h11) begin failures++; $display("FAIL wa_wb_addr got=%h exp=11", mem_addr); end
    checks++; if (mem_wdata !== BAW) begin failures++; $display("FAIL wa_wb_data got=%h exp=%h", mem_wdata, BAW); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    req(1'b1, 1'b0, 30'h10, 32'h0);
    fill(B0);
    req(1'b0, 1'b1, 30'h10, 32'hDEADBEEF);
    tick;
    req(1'b1, 1'b0, 30'h20, 32'h0);
    fill(B1);
    req(1'b1, 1'b0, 30'h30, 32'h0);
    tick;
    checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL mid_pre_wb got=%b exp=1", mem_write); end
    proc_reset_n = 1'b0;
    tick;
    checks++; if ({mem_write, mem_read} !== 2'b00) begin failures++; $display("FAIL mid_abort got=%b exp=00", {mem_write, mem_read}); end
    checks++; if (mem_addr !== 28'h0 || mem_wdata !== 128'h0) begin failures++; $display("FAIL mid_clear got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    proc_reset_n = 1'b1;
    req(1'b1, 1'b0, 30'h10, 32'h0);
    #1;
    checks++; if (proc_stall !== 1'b1) begin failures++; $display("FAIL mid_miss10 got=%b exp=1", proc_stall); end
    tick;
    checks++; if ({mem_read, mem_write} !== 2'b10) begin failures++; $display("FAIL mid_refetch got=%b exp=10", {mem_read, mem_write}); end
    checks++; if (mem_addr !== 28'h04) begin failures++; $display("FAIL mid_refetch_addr got=%h exp=04", mem_addr); end
  endtask

  initial begin
    proc_reset_n = 1'b0;
    req(1'b0, 1'b0, 30'h0, 32'h0);
    mem_ready = 1'b0;
    mem_rdata = '0;
    test_reset;
    test_cold_read;
    test_lru;
    test_dirty_slow;
    test_write_alloc;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
